// File: rtl/game_pkg.sv
// Shared game definitions: lane state encoding and the
// one-hot Player lane vectors also used by the obstacle stage.
package game_pkg;

  localparam int PLAYER_W = 7;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_t;

  localparam logic [PLAYER_W-1:0] PLAYER_L0 = 7'b0000001;
  localparam logic [PLAYER_W-1:0] PLAYER_L1 = 7'b0000100;
  localparam logic [PLAYER_W-1:0] PLAYER_L2 = 7'b0010000;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser, debounce and press detect.
// Debounce counter present only with PLAYER_DEBOUNCE_EN defined.
module btn_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic s1;
  logic s2;
  logic db;
  logic db_prev;

  // Two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef PLAYER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Accept a new level only after it stays stable long enough
  always_ff @(posedge clk) begin
    if (!reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (DEBOUNCE_CYCLES != 0);
  assign db = s2;
`endif

  // Previous debounced level for rising-edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db;
    end
  end

  assign press = db & ~db_prev;

endmodule

// File: rtl/player_lane_ctrl.sv
// Three-lane player position from left/right buttons.
// PLAYER_DEBOUNCE_EN selects the counter-based button debounce.
module player_lane_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                BtnL,
  input  logic                BtnR,
  input  logic                Freeze,
  output logic [PLAYER_W-1:0] Player,
  output logic                Moved
);

  logic press_l;
  logic press_r;
  logic go_l;
  logic go_r;
  lane_t lane;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk  (Clk),
    .reset(Reset),
    .btn  (BtnL),
    .press(press_l)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk  (Clk),
    .reset(Reset),
    .btn  (BtnR),
    .press(press_r)
  );

  // Simultaneous presses cancel; frozen presses are dropped
  assign go_l = press_l & ~press_r & ~Freeze;
  assign go_r = press_r & ~press_l & ~Freeze;

  // Lane FSM with registered Player vector and Moved pulse
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      lane   <= LANE1;
      Player <= PLAYER_L1;
      Moved  <= 1'b0;
    end else begin
      Moved <= 1'b0;
      unique case (1'b1)
        go_l && (lane == LANE2): begin
          lane   <= LANE1;
          Player <= PLAYER_L1;
          Moved  <= 1'b1;
        end
        go_l && (lane == LANE1): begin
          lane   <= LANE0;
          Player <= PLAYER_L0;
          Moved  <= 1'b1;
        end
        go_r && (lane == LANE0): begin
          lane   <= LANE1;
          Player <= PLAYER_L1;
          Moved  <= 1'b1;
        end
        go_r && (lane == LANE1): begin
          lane   <= LANE2;
          Player <= PLAYER_L2;
          Moved  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
